// File: rtl/reflet_bus_fabric.sv
// Reflet bus fabric: steers CPU accesses to instruction, data or peripheral targets,
// inserting fixed wait states for memories and a ready timeout for peripherals.
module reflet_bus_fabric #(
    parameter int                  wordsize    = 16,
    parameter logic [wordsize-1:0] data_base   = {1'b1, {(wordsize-1){1'b0}}},
    parameter logic [wordsize-1:0] periph_base = {{(wordsize-8){1'b1}}, 8'h00},
    parameter int                  inst_wait   = 0,
    parameter int                  data_wait   = 0,
    parameter int                  timeout     = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic [wordsize-1:0] cpu_addr,
    input  logic [wordsize-1:0] cpu_wdata,
    input  logic                cpu_write_en,
    output logic [wordsize-1:0] cpu_rdata,
    output logic                cpu_enable,
    input  logic                err_clear,
    output logic                bus_error,
    output logic [wordsize-1:0] tgt_addr,
    output logic [wordsize-1:0] tgt_wdata,
    output logic                tgt_write_en,
    output logic                inst_en,
    output logic                data_en,
    input  logic [wordsize-1:0] inst_rdata,
    input  logic [wordsize-1:0] data_rdata,
    output logic                periph_en,
    output logic [7:0]          periph_addr,
    output logic [7:0]          periph_wdata,
    output logic                periph_write_en,
    input  logic [7:0]          periph_rdata,
    input  logic                periph_ready
);

    // state  | meaning
    // IDLE   | no access in flight; zero-wait accesses complete here
    // WAIT   | memory access latched, counting down wait states
    // PERIPH | peripheral access latched, waiting for ready or timeout
    typedef enum logic [1:0] {IDLE, WAIT, PERIPH} state_t;
    typedef enum logic [1:0] {RG_INST, RG_DATA, RG_PERIPH} region_t;

    localparam int lane_w   = $clog2(wordsize / 8);
    localparam int max_wait = (inst_wait > data_wait) ? inst_wait : data_wait;
    localparam int max_cnt  = (max_wait > timeout) ? max_wait : timeout;
    localparam int cnt_w    = $clog2(max_cnt + 1);

    // Counters load N-1 so the terminal compare at zero lands on the completing cycle.
    localparam logic [cnt_w-1:0] inst_load = (inst_wait > 0) ? cnt_w'(inst_wait - 1) : '0;
    localparam logic [cnt_w-1:0] data_load = (data_wait > 0) ? cnt_w'(data_wait - 1) : '0;
    localparam logic [cnt_w-1:0] tmo_load  = cnt_w'(timeout - 1);

    state_t                state_q, state_d;
    logic [cnt_w-1:0]      cnt_q, cnt_d;
    logic [wordsize-1:0]   addr_q, addr_d;
    logic [wordsize-1:0]   wdata_q, wdata_d;
    logic                  we_q, we_d;
    region_t               region_q, region_d;
    logic                  bus_error_q, bus_error_d;

    region_t               dec_region;
    region_t               eff_region;
    logic [wordsize-1:0]   eff_addr;
    logic [wordsize-1:0]   eff_wdata;
    logic [lane_w-1:0]     lane;
    logic [wordsize-1:0]   mem_rdata;
    logic [wordsize-1:0]   lane_rdata;
    logic                  mem_zero;
    logic [cnt_w-1:0]      mem_load;
    logic                  timeout_hit;

    always_comb begin
        if (cpu_addr < data_base) begin
            dec_region = RG_INST;
        end else if (cpu_addr < periph_base) begin
            dec_region = RG_DATA;
        end else begin
            dec_region = RG_PERIPH;
        end
    end

    // Outside IDLE the latched request drives the targets; live CPU inputs are ignored.
    assign eff_addr   = (state_q == IDLE) ? cpu_addr   : addr_q;
    assign eff_wdata  = (state_q == IDLE) ? cpu_wdata  : wdata_q;
    assign eff_region = (state_q == IDLE) ? dec_region : region_q;
    assign lane       = eff_addr[lane_w-1:0];

    assign tgt_addr     = eff_addr >> lane_w;
    assign tgt_wdata    = eff_wdata;
    assign periph_addr  = eff_addr[7:0] - periph_base[7:0];
    assign periph_wdata = eff_wdata[{lane, 3'b000} +: 8];
    assign bus_error    = bus_error_q;

    assign mem_rdata  = (eff_region == RG_INST) ? inst_rdata : data_rdata;
    assign lane_rdata = {{(wordsize-8){1'b0}}, periph_rdata} << {lane, 3'b000};
    assign mem_zero   = (dec_region == RG_INST) ? (inst_wait == 0) : (data_wait == 0);
    assign mem_load   = (dec_region == RG_INST) ? inst_load : data_load;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        we_d            = we_q;
        region_d        = region_q;
        timeout_hit     = 1'b0;
        cpu_enable      = 1'b1;
        cpu_rdata       = '0;
        inst_en         = 1'b0;
        data_en         = 1'b0;
        tgt_write_en    = 1'b0;
        periph_en       = 1'b0;
        periph_write_en = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req && reset) begin
                    addr_d   = cpu_addr;
                    wdata_d  = cpu_wdata;
                    we_d     = cpu_write_en;
                    region_d = dec_region;
                    if (dec_region == RG_PERIPH) begin
                        periph_en       = 1'b1;
                        periph_write_en = cpu_write_en;
                        if (periph_ready) begin
                            cpu_rdata = lane_rdata;
                        end else begin
                            cpu_enable = 1'b0;
                            cnt_d      = tmo_load;
                            state_d    = PERIPH;
                        end
                    end else begin
                        inst_en = (dec_region == RG_INST);
                        data_en = (dec_region == RG_DATA);
                        if (mem_zero) begin
                            tgt_write_en = cpu_write_en;
                            cpu_rdata    = mem_rdata;
                        end else begin
                            cpu_enable = 1'b0;
                            cnt_d      = mem_load;
                            state_d    = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                inst_en = (region_q == RG_INST);
                data_en = (region_q == RG_DATA);
                if (cnt_q == '0) begin
                    tgt_write_en = we_q;
                    cpu_rdata    = mem_rdata;
                    state_d      = IDLE;
                end else begin
                    cpu_enable = 1'b0;
                    cnt_d      = cnt_q - cnt_w'(1);
                end
            end
            PERIPH: begin
                if (cnt_q == '0) begin
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end else begin
                    periph_en       = 1'b1;
                    periph_write_en = we_q;
                    if (periph_ready) begin
                        cpu_rdata = lane_rdata;
                        state_d   = IDLE;
                    end else begin
                        cpu_enable = 1'b0;
                        cnt_d      = cnt_q - cnt_w'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A timeout in the same cycle as a clear must leave the flag set.
        if (timeout_hit) begin
            bus_error_d = 1'b1;
        end else if (err_clear) begin
            bus_error_d = 1'b0;
        end else begin
            bus_error_d = bus_error_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            region_q    <= RG_INST;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            region_q    <= region_d;
            bus_error_q <= bus_error_d;
        end
    end

endmodule

// File: tb/tb_reflet_bus_fabric.sv
// Bench for reflet_bus_fabric: three configurations checked every cycle against an
// access-level model, plus directed literal checks on the key scenarios.
module tb_reflet_bus_fabric;

    localparam int N = 3;

    logic clk;
    logic rst_n;

    logic [N-1:0]       req, we, eclr, prdy;
    logic [N-1:0][63:0] addr, wdata, irdata, drdata;
    logic [N-1:0][7:0]  prd;

    wire  [N-1:0][63:0] o_rdata, o_taddr, o_twdata;
    wire  [N-1:0]       o_en, o_err, o_twe, o_ien, o_den, o_pen, o_pwe;
    wire  [N-1:0][7:0]  o_paddr, o_pwdata;

    int total = 0;
    int bad   = 0;

    // instance 0: 16-bit, no memory waits, timeout 4
    reflet_bus_fabric #(.wordsize(16), .inst_wait(0), .data_wait(0), .timeout(4)) u_dut0 (
        .clk(clk), .reset(rst_n), .cpu_req(req[0]), .cpu_addr(addr[0][15:0]),
        .cpu_wdata(wdata[0][15:0]), .cpu_write_en(we[0]), .cpu_rdata(o_rdata[0][15:0]),
        .cpu_enable(o_en[0]), .err_clear(eclr[0]), .bus_error(o_err[0]),
        .tgt_addr(o_taddr[0][15:0]), .tgt_wdata(o_twdata[0][15:0]), .tgt_write_en(o_twe[0]),
        .inst_en(o_ien[0]), .data_en(o_den[0]), .inst_rdata(irdata[0][15:0]),
        .data_rdata(drdata[0][15:0]), .periph_en(o_pen[0]), .periph_addr(o_paddr[0]),
        .periph_wdata(o_pwdata[0]), .periph_write_en(o_pwe[0]), .periph_rdata(prd[0]),
        .periph_ready(prdy[0]));

    // instance 1: 16-bit, inst 1 wait, data 2 waits
    reflet_bus_fabric #(.wordsize(16), .inst_wait(1), .data_wait(2), .timeout(255)) u_dut1 (
        .clk(clk), .reset(rst_n), .cpu_req(req[1]), .cpu_addr(addr[1][15:0]),
        .cpu_wdata(wdata[1][15:0]), .cpu_write_en(we[1]), .cpu_rdata(o_rdata[1][15:0]),
        .cpu_enable(o_en[1]), .err_clear(eclr[1]), .bus_error(o_err[1]),
        .tgt_addr(o_taddr[1][15:0]), .tgt_wdata(o_twdata[1][15:0]), .tgt_write_en(o_twe[1]),
        .inst_en(o_ien[1]), .data_en(o_den[1]), .inst_rdata(irdata[1][15:0]),
        .data_rdata(drdata[1][15:0]), .periph_en(o_pen[1]), .periph_addr(o_paddr[1]),
        .periph_wdata(o_pwdata[1]), .periph_write_en(o_pwe[1]), .periph_rdata(prd[1]),
        .periph_ready(prdy[1]));

    // instance 2: 32-bit, data 3 waits, default timeout
    reflet_bus_fabric #(.wordsize(32), .inst_wait(0), .data_wait(3), .timeout(255)) u_dut2 (
        .clk(clk), .reset(rst_n), .cpu_req(req[2]), .cpu_addr(addr[2][31:0]),
        .cpu_wdata(wdata[2][31:0]), .cpu_write_en(we[2]), .cpu_rdata(o_rdata[2][31:0]),
        .cpu_enable(o_en[2]), .err_clear(eclr[2]), .bus_error(o_err[2]),
        .tgt_addr(o_taddr[2][31:0]), .tgt_wdata(o_twdata[2][31:0]), .tgt_write_en(o_twe[2]),
        .inst_en(o_ien[2]), .data_en(o_den[2]), .inst_rdata(irdata[2][31:0]),
        .data_rdata(drdata[2][31:0]), .periph_en(o_pen[2]), .periph_addr(o_paddr[2]),
        .periph_wdata(o_pwdata[2]), .periph_write_en(o_pwe[2]), .periph_rdata(prd[2]),
        .periph_ready(prdy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int p_ws(input int i);
        return (i == 2) ? 32 : 16;
    endfunction
    function automatic int p_iw(input int i);
        return (i == 1) ? 1 : 0;
    endfunction
    function automatic int p_dw(input int i);
        return (i == 1) ? 2 : ((i == 2) ? 3 : 0);
    endfunction
    function automatic int p_to(input int i);
        return (i == 0) ? 4 : 255;
    endfunction
    function automatic logic [63:0] p_db(input int i);
        return (i == 2) ? 64'h8000_0000 : 64'h8000;
    endfunction
    function automatic logic [63:0] p_pb(input int i);
        return (i == 2) ? 64'hFFFF_FF00 : 64'hFF00;
    endfunction
    function automatic logic [63:0] msk(input int i);
        return (p_ws(i) == 32) ? 64'hFFFF_FFFF : 64'hFFFF;
    endfunction
    function automatic int region_of(input int i, input logic [63:0] a);
        if (a < p_db(i)) return 0;
        if (a < p_pb(i)) return 1;
        return 2;
    endfunction

    task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%h want=%h at %0t", nm, i, act, exp, $time);
        end
    endtask

    // Access-level model: elapsed cycles since the request decide stall/complete.
    logic [N-1:0]       m_busy, m_we, m_err;
    logic [N-1:0][63:0] m_addr, m_wdata;
    int                 m_e [N];

    task automatic model_step(input int i);
        logic [63:0] a, wd, x_rdata;
        logic        w, act, done, tmo;
        logic        x_en, x_ien, x_den, x_pen, x_pwe, x_twe;
        int          r, e, n, lane, lb;
        if (!rst_n) begin
            m_busy[i] = 1'b0; m_e[i] = 0; m_err[i] = 1'b0;
            chk("rst_en", i, {63'd0, o_en[i]}, 64'd1);
            chk("rst_rdata", i, o_rdata[i] & msk(i), 64'd0);
            chk("rst_sel", i, {61'd0, o_ien[i], o_den[i], o_pen[i]}, 64'd0);
            chk("rst_strobe", i, {62'd0, o_twe[i], o_pwe[i]}, 64'd0);
            chk("rst_err", i, {63'd0, o_err[i]}, 64'd0);
            return;
        end
        lb = (p_ws(i) == 32) ? 2 : 1;
        x_en = 1'b1; x_ien = 1'b0; x_den = 1'b0; x_pen = 1'b0; x_pwe = 1'b0; x_twe = 1'b0;
        x_rdata = 64'd0; done = 1'b0; tmo = 1'b0;
        act = m_busy[i] || req[i];
        if (m_busy[i]) begin
            a = m_addr[i]; wd = m_wdata[i]; w = m_we[i]; e = m_e[i];
        end else begin
            a = addr[i] & msk(i); wd = wdata[i] & msk(i); w = we[i]; e = 0;
        end
        r    = region_of(i, a);
        lane = int'(a % 64'(p_ws(i) / 8));
        if (act) begin
            if (r < 2) begin
                n = (r == 0) ? p_iw(i) : p_dw(i);
                if (r == 0) x_ien = 1'b1; else x_den = 1'b1;
                if (e >= n) begin
                    done = 1'b1; x_twe = w;
                    x_rdata = ((r == 0) ? irdata[i] : drdata[i]) & msk(i);
                end else begin
                    x_en = 1'b0;
                end
                chk("taddr", i, o_taddr[i] & msk(i), a >> lb);
                chk("twdata", i, o_twdata[i] & msk(i), wd);
            end else if (e >= p_to(i)) begin
                tmo = 1'b1; done = 1'b1;
            end else begin
                x_pen = 1'b1; x_pwe = w;
                chk("paddr", i, {56'd0, o_paddr[i]}, (a - p_pb(i)) & 64'hFF);
                chk("pwdata", i, {56'd0, o_pwdata[i]}, (wd >> (8 * lane)) & 64'hFF);
                if (prdy[i]) begin
                    done = 1'b1; x_rdata = {56'd0, prd[i]} << (8 * lane);
                end else begin
                    x_en = 1'b0;
                end
            end
        end
        chk("en", i, {63'd0, o_en[i]}, {63'd0, x_en});
        chk("rdata", i, o_rdata[i] & msk(i), x_rdata);
        chk("sel", i, {61'd0, o_ien[i], o_den[i], o_pen[i]}, {61'd0, x_ien, x_den, x_pen});
        chk("strobe", i, {62'd0, o_twe[i], o_pwe[i]}, {62'd0, x_twe, x_pwe});
        chk("err", i, {63'd0, o_err[i]}, {63'd0, m_err[i]});
        if (act && !done) begin
            m_busy[i] = 1'b1; m_e[i] = e + 1;
            m_addr[i] = a; m_wdata[i] = wd; m_we[i] = w;
        end else begin
            m_busy[i] = 1'b0; m_e[i] = 0;
        end
        if (tmo) m_err[i] = 1'b1;
        else if (eclr[i]) m_err[i] = 1'b0;
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) model_step(i);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        req = '0; we = '0; eclr = '0; prdy = '0; addr = '0; wdata = '0;
        irdata = '0; drdata = '0; prd = '0; rst_n = 1'b0;
        settle();
        chk("lit_rst_en", 2, {63'd0, o_en[2]}, 64'd1);
        chk("lit_rst_err", 0, {63'd0, o_err[0]}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // instance 0: zero-wait write to data region
        cyc(); req[0] = 1; we[0] = 1; addr[0] = 64'h8002; wdata[0] = 64'hBEEF;
        settle();
        chk("lit_a_den", 0, {63'd0, o_den[0]}, 64'd1);
        chk("lit_a_taddr", 0, o_taddr[0] & 64'hFFFF, 64'h4001);
        chk("lit_a_twe", 0, {63'd0, o_twe[0]}, 64'd1);
        chk("lit_a_en", 0, {63'd0, o_en[0]}, 64'd1);
        cyc(); we[0] = 0; addr[0] = 64'h0010; irdata[0] = 64'h5A5A;
        settle();
        chk("lit_a_irdata", 0, o_rdata[0] & 64'hFFFF, 64'h5A5A);
        cyc(); addr[0] = 64'h8004; drdata[0] = 64'hC3C3;
        settle();
        chk("lit_a_drdata", 0, o_rdata[0] & 64'hFFFF, 64'hC3C3);
        cyc(); addr[0] = 64'hFF05; we[0] = 1; wdata[0] = 64'h12AB; prdy[0] = 1;
        settle();
        chk("lit_a_paddr", 0, {56'd0, o_paddr[0]}, 64'h05);
        chk("lit_a_pwdata", 0, {56'd0, o_pwdata[0]}, 64'h12);
        chk("lit_a_pzero", 0, {63'd0, o_en[0]}, 64'd1);
        cyc(); we[0] = 0; prd[0] = 8'h3C;
        settle();
        chk("lit_a_lane1", 0, o_rdata[0] & 64'hFFFF, 64'h3C00);
        cyc(); addr[0] = 64'hFF04;
        settle();
        chk("lit_a_lane0", 0, o_rdata[0] & 64'hFFFF, 64'h003C);
        // timeout after 4 stalled cycles
        cyc(); prdy[0] = 0; addr[0] = 64'hFF10;
        settle();
        for (int k = 2; k <= 4; k++) begin
            cyc(); settle();
            chk("lit_a_tstall", 0, {63'd0, o_en[0]}, 64'd0);
        end
        cyc(); settle();
        chk("lit_a_tmo_en", 0, {63'd0, o_en[0]}, 64'd1);
        chk("lit_a_tmo_pen", 0, {63'd0, o_pen[0]}, 64'd0);
        chk("lit_a_tmo_rd", 0, o_rdata[0] & 64'hFFFF, 64'd0);
        cyc(); req[0] = 0; settle();
        chk("lit_a_err_set", 0, {63'd0, o_err[0]}, 64'd1);
        cyc(); eclr[0] = 1; settle();
        cyc(); eclr[0] = 0; settle();
        chk("lit_a_err_clr", 0, {63'd0, o_err[0]}, 64'd0);
        // timeout while clear is held
        cyc(); req[0] = 1; addr[0] = 64'hFF20; eclr[0] = 1; settle();
        repeat (4) begin cyc(); settle(); end
        cyc(); req[0] = 0; eclr[0] = 0; settle();
        chk("lit_a_err_hold", 0, {63'd0, o_err[0]}, 64'd1);

        // instance 1: data read with 2 waits
        cyc(); req[1] = 1; we[1] = 0; addr[1] = 64'h8000; drdata[1] = 64'h1234;
        settle();
        chk("lit_b_en1", 1, {63'd0, o_en[1]}, 64'd0);
        cyc(); settle();
        chk("lit_b_en2", 1, {63'd0, o_en[1]}, 64'd0);
        cyc(); settle();
        chk("lit_b_en3", 1, {63'd0, o_en[1]}, 64'd1);
        chk("lit_b_rdata", 1, o_rdata[1] & 64'hFFFF, 64'h1234);
        chk("lit_b_twe", 1, {63'd0, o_twe[1]}, 64'd0);
        // back-to-back inst write with 1 wait; CPU inputs change mid-access
        cyc(); addr[1] = 64'h0004; we[1] = 1; wdata[1] = 64'h7777;
        settle();
        chk("lit_b_iw1", 1, {63'd0, o_twe[1]}, 64'd0);
        cyc(); addr[1] = 64'h9000; wdata[1] = 64'h1111; we[1] = 0;
        settle();
        chk("lit_b_iw2", 1, {63'd0, o_twe[1]}, 64'd1);
        chk("lit_b_itaddr", 1, o_taddr[1] & 64'hFFFF, 64'h0002);
        chk("lit_b_itwd", 1, o_twdata[1] & 64'hFFFF, 64'h7777);
        cyc(); req[1] = 0; settle();

        // instance 2: 32-bit peripheral read, ready after 3 stalls
        cyc(); req[2] = 1; we[2] = 0; addr[2] = 64'hFFFF_FF03; prd[2] = 8'hA5;
        settle();
        chk("lit_c_paddr", 2, {56'd0, o_paddr[2]}, 64'h03);
        repeat (2) begin cyc(); settle(); end
        chk("lit_c_stall3", 2, {63'd0, o_en[2]}, 64'd0);
        cyc(); prdy[2] = 1; settle();
        chk("lit_c_rdata", 2, o_rdata[2] & 64'hFFFF_FFFF, 64'hA500_0000);
        cyc(); prdy[2] = 0; addr[2] = 64'h10; irdata[2] = 64'hDEAD_BEEF;
        settle();
        chk("lit_c_irdata", 2, o_rdata[2] & 64'hFFFF_FFFF, 64'hDEAD_BEEF);
        chk("lit_c_taddr", 2, o_taddr[2] & 64'hFFFF_FFFF, 64'h4);
        cyc(); addr[2] = 64'hFFFF_FF02; we[2] = 1; wdata[2] = 64'h00CC_0000;
        settle();
        cyc(); wdata[2] = 64'h0033_0000; prdy[2] = 1;
        settle();
        chk("lit_c_pwlatch", 2, {56'd0, o_pwdata[2]}, 64'hCC);
        // reset during a 3-wait data write
        cyc(); prdy[2] = 0; addr[2] = 64'h8000_0010; wdata[2] = 64'hCAFE_F00D;
        settle();
        cyc(); #1 rst_n = 1'b0; #1;
        chk("lit_c_rst_en", 2, {63'd0, o_en[2]}, 64'd1);
        chk("lit_c_rst_den", 2, {63'd0, o_den[2]}, 64'd0);
        chk("lit_c_rst_twe", 2, {63'd0, o_twe[2]}, 64'd0);
        req[2] = 0; we[2] = 0;
        settle();
        cyc(); rst_n = 1'b1;
        repeat (5) begin
            settle();
            chk("lit_c_nowrite", 2, {63'd0, o_twe[2]}, 64'd0);
            cyc();
        end
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reflet_bus_fabric.md
REFLET_BUS_FABRIC -- requirements
Module: reflet_bus_fabric

Interface
REQ-001 SHALL have parameter wordsize, default 16, meaning CPU data/address width; legal values 16, 32, 64.
REQ-002 SHALL have parameter data_base, default 2^(wordsize-1), meaning first byte address of the data region.
REQ-003 SHALL have parameter periph_base, default 2^wordsize-256, meaning first byte address of the peripheral region.
REQ-004 SHALL have parameter inst_wait, default 0, meaning fixed wait states for the instruction region.
REQ-005 SHALL have parameter data_wait, default 0, meaning fixed wait states for the data region.
REQ-006 SHALL have parameter timeout, default 255, meaning peripheral ready timeout in cycles (>=1).
REQ-007 SHALL have ports, clock and reset first:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access valid
- cpu_addr  in  wordsize  byte address
- cpu_wdata  in  wordsize  write data
- cpu_write_en  in  1  write access
- cpu_rdata  out  wordsize  read data to CPU
- cpu_enable  out  1  low stalls CPU
- err_clear  in  1  clears bus_error
- bus_error  out  1  sticky timeout flag
- tgt_addr  out  wordsize  word address = byte address >> log2(wordsize/8)
- tgt_wdata  out  wordsize  write data to inst/data memories
- tgt_write_en  out  1  memory write strobe
- inst_en, data_en  out  1 each  region selects
- inst_rdata, data_rdata  in  wordsize each  memory read data
- periph_en  out  1  peripheral select
- periph_addr  out  8  byte offset within peripheral region
- periph_wdata  out  8  steered write byte
- periph_write_en  out  1  peripheral write
- periph_rdata  in  8  peripheral read byte
- periph_ready  in  1  peripheral access complete

Function
REQ-008 Decode SHALL be: addr < data_base -> inst; data_base <= addr < periph_base -> data; addr >= periph_base -> periph; exactly one select active per access.
REQ-009 FSM states SHALL be IDLE, WAIT, PERIPH.
REQ-010 In IDLE with cpu_req=0, cpu_enable SHALL be 1, all selects and write strobes 0, cpu_rdata 0.
REQ-011 In IDLE with cpu_req=1 to a region with 0 wait states, the access SHALL complete in the same cycle: select and tgt_write_en asserted combinationally, cpu_rdata = selected rdata, cpu_enable=1.
REQ-012 On cpu_req=1 to a region with N>0 wait states, addr/wdata/write_en/region SHALL be latched, state -> WAIT, cpu_enable low for exactly N cycles, completion on cycle N+1 with cpu_enable=1 and valid cpu_rdata.
REQ-013 In WAIT, the select SHALL be held on every cycle; tgt_write_en SHALL be asserted only in the completing cycle (single write commit).
REQ-014 Peripheral access SHALL latch the request, enter PERIPH, hold periph_en and periph_write_en from the request cycle until completion; cpu_enable=0 until the cycle periph_ready=1, which completes the access (cpu_enable=1).
REQ-015 periph_ready=1 in the request cycle itself SHALL complete the access with zero stall.
REQ-016 Byte lane k = addr[log2(wordsize/8)-1:0]; periph_wdata SHALL be cpu_wdata[8k+7:8k]; cpu_rdata SHALL carry periph_rdata in lane k and zero in all other lanes.
REQ-017 If periph_ready is not seen within timeout cycles of the request, the access SHALL complete with cpu_rdata=0, bus_error set to 1, periph_en dropped, state -> IDLE.
REQ-018 bus_error SHALL stay 1 until err_clear=1; a timeout and err_clear in the same cycle SHALL leave bus_error=1.
REQ-019 After any completion, the next cpu_req SHALL be accepted in the immediately following cycle (no dead cycle).
REQ-020 CPU inputs changing during WAIT/PERIPH SHALL be ignored; latched values drive targets.
REQ-021 Wait and timeout counters SHALL be $clog2(max(inst_wait,data_wait,timeout)+1) bits wide and never wrap.

Reset
REQ-022 reset=0 SHALL asynchronously force state IDLE, counters 0, latches 0, bus_error 0, cpu_enable 1, all selects/strobes 0.
REQ-023 reset asserted mid-access SHALL abort the access with no write committed after reset release.

Verification
REQ-024 wordsize=16, waits 0: write 0xBEEF to 0x8002 -> data_en=1, tgt_addr=0x4001, tgt_write_en=1 same cycle, cpu_enable never 0.
REQ-025 data_wait=2: read 0x8000 with data_rdata=0x1234 -> cpu_enable 0,0,1; cpu_rdata=0x1234 on 3rd cycle; tgt_write_en never set.
REQ-026 wordsize=32: read 0xFFFFFF03, periph_ready after 3 cycles with periph_rdata=0xA5 -> periph_addr=0x03, cpu_rdata=0xA5000000, stall 3 cycles.
REQ-027 timeout=4, periph_ready held 0 -> completion on cycle 5, cpu_rdata=0, bus_error=1; err_clear pulse -> bus_error=0.
REQ-028 reset=0 during WAIT of a data_wait=3 write -> outputs at reset values immediately, no tgt_write_en pulse afterwards.
